store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 151 +++++++++++++++
 tb/tb_store_buffer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Four-entry store buffer between the processor and a single-port data
//   memory. Accepted stores queue in a FIFO and drain to memory in acceptance
//   order. A load takes the memory port unless the buffer is full. A load
//   returns the youngest buffered store to the same address, otherwise the
//   memory read data. A flush stops new stores and drains the FIFO, then
//   raises flush_done for one cycle.
//
// Ports
//   CLK, RST            clock; asynchronous active-high reset
//   st_valid/addr/data  store request; accepted when st_valid && st_ready
//   st_ready            store can be accepted this cycle
//   ld_valid/addr       load request (combinational read)
//   ld_data             load result, same cycle
//   ld_stall            load not served this cycle (buffer full, drain wins)
//   flush               request to drain all pending stores
//   flush_done          one-cycle pulse when the flush has completed
//   count               number of buffered entries, 0..4
//   mem_addr/wdata/we   data memory port
//   mem_rdata           data memory combinational read data
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_stall,
  input  logic              flush,
  output logic              flush_done,
  output logic [2:0]        count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                          state, state_nxt;
  logic [DEPTH-1:0][ADDR_W-1:0]    ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0]    ent_data;
  logic [DEPTH-1:0]                ent_vld;
  logic [PTR_W-1:0]                head, tail;

  logic                            full, empty;
  logic                            push, pop;
  logic                            fwd_hit;
  logic [DATA_W-1:0]               fwd_data;

  assign full  = (count == 3'(DEPTH));
  assign empty = (count == 3'd0);

  // Stores are refused while full (no full-bypass) and for the whole flush.
  assign st_ready = !full && (state == RUN);
  assign push     = st_valid && st_ready;

  // A load owns the memory port unless the buffer is full; then the head
  // drains so the stalled load can make progress next cycle.
  assign pop      = !empty && (!ld_valid || full);
  assign ld_stall = ld_valid && full;

  always_comb begin
    mem_we    = pop;
    mem_wdata = pop ? ent_data[head] : '0;
    if (pop)           mem_addr = ent_addr[head];
    else if (ld_valid) mem_addr = ld_addr;
    else               mem_addr = '0;
  end

  // Forwarding: walk entries oldest to youngest starting at head, so the
  // last hit is the youngest matching store. The store presented this cycle
  // is not in the array yet and is therefore never forwarded.
  always_comb begin : fwd
    logic [PTR_W-1:0] slot;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if (ent_vld[slot] && ent_addr[slot] == ld_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[slot];
      end
    end
  end

  assign ld_data = fwd_hit ? fwd_data : mem_rdata;

  // FSM: flush is only sampled in RUN. flush_done fires in the FLUSH cycle
  // that sees an empty buffer, so a flush on an empty buffer still spends
  // one cycle in FLUSH before pulsing.
  always_comb begin
    state_nxt  = state;
    flush_done = 1'b0;
    case (state)
      RUN:   if (flush) state_nxt = FLUSH;
      FLUSH: if (empty) begin
               flush_done = 1'b1;
               state_nxt  = RUN;
             end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= RUN;
    else     state <= state_nxt;
  end

  // FIFO storage. With count < DEPTH and count > 0, head != tail, so a
  // simultaneous push and pop never touch the same slot.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ent_addr <= '0;
      ent_data <= '0;
      ent_vld  <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        ent_addr[tail] <= st_addr;
        ent_data[tail] <= st_data;
        ent_vld[tail]  <= 1'b1;
        tail           <= tail + 1'b1;
      end
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//   Directed bench for store_buffer. Inputs change 1 ns after the rising edge;
//   outputs are sampled on the falling edge of the same cycle. mem_rdata is
//   held at a fixed background value so forwarded and memory data differ.
// -----------------------------------------------------------------------------
module tb_store_buffer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       st_valid;
  logic [7:0] st_addr, st_data;
  logic       st_ready;
  logic       ld_valid;
  logic [7:0] ld_addr, ld_data;
  logic       ld_stall;
  logic       flush, flush_done;
  logic [2:0] count;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;

  localparam logic [7:0] MEM_BG = 8'hEE;

  int checks = 0;
  int errors = 0;

  store_buffer dut (
    .CLK       (CLK),
    .RST       (RST),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ready  (st_ready),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_stall  (ld_stall),
    .flush     (flush),
    .flush_done(flush_done),
    .count     (count),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge, where inputs are changed.
  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic store(input logic v, input logic [7:0] a, input logic [7:0] d);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic chk_write(input string tag, input logic [7:0] a, input logic [7:0] d);
    chk({tag, ".we"},    mem_we,    1);
    chk({tag, ".addr"},  mem_addr,  a);
    chk({tag, ".wdata"}, mem_wdata, d);
  endtask

  initial begin
    RST = 1'b1;
    store(0, 8'h00, 8'h00);
    ld_valid  = 1'b0;
    ld_addr   = 8'h00;
    flush     = 1'b0;
    mem_rdata = MEM_BG;

    // Reset state
    @(negedge CLK);
    chk("rst.st_ready",   st_ready,   1);
    chk("rst.mem_we",     mem_we,     0);
    chk("rst.flush_done", flush_done, 0);
    chk("rst.ld_stall",   ld_stall,   0);
    chk("rst.count",      count,      0);
    chk("rst.mem_addr",   mem_addr,   0);
    next_cyc();
    RST = 1'b0;

    // Single store drains the cycle after acceptance
    next_cyc();
    store(1, 8'h10, 8'h21);
    @(negedge CLK);
    chk("s1.we_pre", mem_we, 0);
    next_cyc();
    store(0, 8'h00, 8'h00);
    @(negedge CLK);
    chk("s1.count1", count, 1);
    chk_write("s1.drain", 8'h10, 8'h21);
    next_cyc();
    @(negedge CLK);
    chk("s1.count0", count, 0);
    chk("s1.we_post", mem_we, 0);

    // Forwarding: youngest match wins; presented st_data is not forwarded
    next_cyc();
    ld_valid = 1'b1;
    ld_addr  = 8'h2A;
    store(1, 8'h2A, 8'h05);
    @(negedge CLK);
    chk("fw.no_fwd_new", ld_data, MEM_BG);
    next_cyc();
    store(1, 8'h2A, 8'h07);
    @(negedge CLK);
    chk("fw.one", ld_data, 8'h05);
    next_cyc();
    store(0, 8'h00, 8'h00);
    @(negedge CLK);
    chk("fw.young", ld_data, 8'h07);
    chk("fw.we", mem_we, 0);
    chk("fw.count", count, 2);
    chk("fw.addr", mem_addr, 8'h2A);
    ld_addr = 8'h2B;
    #1;
    chk("fw.miss", ld_data, MEM_BG);
    next_cyc();
    ld_valid = 1'b0;
    @(negedge CLK);
    chk_write("fw.w0", 8'h2A, 8'h05);
    next_cyc();
    @(negedge CLK);
    chk_write("fw.w1", 8'h2A, 8'h07);
    next_cyc();
    @(negedge CLK);
    chk("fw.empty", count, 0);

    // Full buffer: load stalls, head drains, then the load is served
    next_cyc();
    ld_valid = 1'b1;
    ld_addr  = 8'h80;
    for (int i = 0; i < 4; i++) begin
      store(1, 8'h40 + 8'(i), 8'h01 + 8'(i));
      @(negedge CLK);
      chk("full.fill_we", mem_we, 0);
      next_cyc();
    end
    store(1, 8'h44, 8'h05);
    @(negedge CLK);
    chk("full.count4", count, 4);
    chk("full.st_ready", st_ready, 0);
    chk("full.ld_stall", ld_stall, 1);
    chk_write("full.drain", 8'h40, 8'h01);
    next_cyc();
    store(0, 8'h00, 8'h00);
    @(negedge CLK);
    chk("full.count3", count, 3);
    chk("full.stall0", ld_stall, 0);
    chk("full.ready1", st_ready, 1);
    chk("full.ld_addr", mem_addr, 8'h80);
    chk("full.ld_data", ld_data, MEM_BG);
    next_cyc();
    ld_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(negedge CLK);
      chk_write("full.order", 8'h40 + 8'(i), 8'h01 + 8'(i));
      next_cyc();
    end
    @(negedge CLK);
    chk("full.empty", count, 0);

    // Enqueue and drain in the same cycle keeps count
    next_cyc();
    ld_valid = 1'b1;
    ld_addr  = 8'h99;
    store(1, 8'h50, 8'h11);
    next_cyc();
    store(1, 8'h51, 8'h12);
    next_cyc();
    ld_valid = 1'b0;
    store(1, 8'h52, 8'h13);
    @(negedge CLK);
    chk("sim.count2a", count, 2);
    chk_write("sim.w0", 8'h50, 8'h11);
    next_cyc();
    store(0, 8'h00, 8'h00);
    @(negedge CLK);
    chk("sim.count2b", count, 2);
    chk_write("sim.w1", 8'h51, 8'h12);
    next_cyc();
    @(negedge CLK);
    chk_write("sim.w2", 8'h52, 8'h13);
    next_cyc();
    @(negedge CLK);
    chk("sim.empty", count, 0);

    // Flush with three pending entries
    next_cyc();
    ld_valid = 1'b1;
    ld_addr  = 8'h99;
    for (int i = 0; i < 3; i++) begin
      store(1, 8'h60 + 8'(i), 8'h21 + 8'(i));
      next_cyc();
    end
    store(0, 8'h00, 8'h00);
    ld_valid = 1'b0;
    flush    = 1'b1;
    @(negedge CLK);
    chk("fl.count3", count, 3);
    chk_write("fl.w0", 8'h60, 8'h21);
    chk("fl.done0", flush_done, 0);
    next_cyc();
    flush = 1'b0;
    store(1, 8'h70, 8'h99);
    for (int i = 1; i < 3; i++) begin
      @(negedge CLK);
      chk("fl.st_ready", st_ready, 0);
      chk("fl.done_n", flush_done, 0);
      chk_write("fl.order", 8'h60 + 8'(i), 8'h21 + 8'(i));
      next_cyc();
    end
    @(negedge CLK);
    chk("fl.done1", flush_done, 1);
    chk("fl.count0", count, 0);
    chk("fl.st_ready_d", st_ready, 0);
    chk("fl.we_d", mem_we, 0);
    next_cyc();
    store(0, 8'h00, 8'h00);
    @(negedge CLK);
    chk("fl.done_off", flush_done, 0);
    chk("fl.run", st_ready, 1);
    chk("fl.no_store", count, 0);

    // Flush while empty
    next_cyc();
    flush = 1'b1;
    @(negedge CLK);
    chk("fe.done0", flush_done, 0);
    next_cyc();
    flush = 1'b0;
    @(negedge CLK);
    chk("fe.done1", flush_done, 1);
    chk("fe.ready0", st_ready, 0);
    next_cyc();
    @(negedge CLK);
    chk("fe.done_off", flush_done, 0);
    chk("fe.run", st_ready, 1);

    // Reset mid-operation discards pending stores
    next_cyc();
    ld_valid = 1'b1;
    ld_addr  = 8'h99;
    for (int i = 0; i < 3; i++) begin
      store(1, 8'h70 + 8'(i), 8'h31 + 8'(i));
      next_cyc();
    end
    store(0, 8'h00, 8'h00);
    ld_valid = 1'b0;
    #1;
    chk("mr.we_pre", mem_we, 1);
    chk("mr.count3", count, 3);
    #1;
    RST = 1'b1;
    #1;
    chk("mr.we_now", mem_we, 0);
    chk("mr.count_now", count, 0);
    chk("mr.ready", st_ready, 1);
    next_cyc();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("mr.no_write", mem_we, 0);
      chk("mr.count", count, 0);
      next_cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
